// File: rtl/alu_cmd_sequencer.sv
// Command/result sequencer around a combinational ALU: registers operands on a
// valid/ready command, captures the settled result one cycle later into a FIFO.
module alu_cmd_sequencer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [2:0]       cmd_sel,
  input  logic             cmd_use_acc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_c,
  input  logic             alu_cf,
  input  logic             alu_of,
  input  logic             alu_out,
  input  logic             alu_zero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH+3:0] res_data,
  output logic [WIDTH-1:0] acc,
  output logic [7:0]       op_count,
  output logic             busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t           state, state_nxt;
  logic             accept, push, pop;
  logic [WIDTH+3:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // rst_n gates cmd_ready so nothing is offered while reset is held
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    push      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = rst_n && (count < FULL);
        accept    = cmd_valid && cmd_ready;
        if (accept) state_nxt = EXEC;
      end
      EXEC: begin
        busy      = 1'b1;
        push      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage 0 -> ALU: operand registers, held between commands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= 3'b000;
    end else if (accept) begin
      alu_a   <= cmd_use_acc ? acc : cmd_a;
      alu_b   <= cmd_b;
      alu_sel <= cmd_sel;
    end
  end

  // ALU -> result stage: capture settled result at the end of EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      op_count <= 8'd0;
    end else if (push) begin
      acc      <= alu_c;
      op_count <= op_count + 8'd1;
    end
  end

  assign pop = res_ready && (count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {alu_c, alu_cf, alu_of, alu_out, alu_zero};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset, so the head is masked while the FIFO is empty
  assign res_valid = (count != '0);
  assign res_data  = res_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural 4-bit ALU attached.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_use_acc;
  logic [3:0] cmd_a, cmd_b;
  logic [2:0] cmd_sel;
  logic [3:0] alu_a, alu_b, alu_c;
  logic [2:0] alu_sel;
  logic       alu_cf, alu_of, alu_out, alu_zero;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic [3:0] acc;
  logic [7:0] op_count;
  logic       busy;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  alu_cmd_sequencer #(.WIDTH(4), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_use_acc(cmd_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_c(alu_c), .alu_cf(alu_cf), .alu_of(alu_of), .alu_out(alu_out), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .acc(acc), .op_count(op_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: cf is carry (add) / borrow (sub), of is signed overflow
  logic [4:0] sum;
  always_comb begin
    sum     = 5'd0;
    alu_c   = 4'd0;
    alu_cf  = 1'b0;
    alu_of  = 1'b0;
    alu_out = 1'b0;
    case (alu_sel)
      3'b000: begin
        sum    = {1'b0, alu_a} + {1'b0, alu_b};
        alu_c  = sum[3:0];
        alu_cf = sum[4];
        alu_of = (alu_a[3] == alu_b[3]) && (sum[3] != alu_a[3]);
      end
      3'b001: begin
        sum    = {1'b0, alu_a} - {1'b0, alu_b};
        alu_c  = sum[3:0];
        alu_cf = alu_a < alu_b;
        alu_of = (alu_a[3] != alu_b[3]) && (sum[3] != alu_a[3]);
      end
      3'b010: alu_c = ~alu_a;
      3'b011: alu_c = alu_a & alu_b;
      3'b100: alu_c = alu_a | alu_b;
      3'b101: alu_c = alu_a ^ alu_b;
      3'b110: alu_out = $signed(alu_a) < $signed(alu_b);
      default: alu_out = (alu_a == alu_b);
    endcase
    alu_zero = (alu_c == 4'd0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every consumed head entry must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) check("unexpected_result", {24'd0, res_data}, 32'hFFFF_FFFF);
      else check("res_data", {24'd0, res_data}, {24'd0, exp_q.pop_front()});
    end
  end

  // Starts and returns 1ns after a rising edge; returns just after the accepting edge
  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel,
                       input logic use_acc, input logic expect_res, input logic [7:0] exp);
    logic got;
    got = 1'b0;
    cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_use_acc = use_acc; cmd_valid = 1'b1;
    if (expect_res) exp_q.push_back(exp);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      got = cmd_ready;
      @(posedge clk); #1;
      if (got) break;
    end
    if (!got) check("accept_timeout", 32'd0, 32'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1);
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sel = '0;
    cmd_use_acc = 1'b0; res_ready = 1'b1;
    #12;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_busy", busy, 0);
    check("rst_acc", acc, 0);
    check("rst_op_count", op_count, 0);
    check("rst_alu_ops", {alu_a, alu_b, alu_sel}, 0);
    #4 rst_n = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", cmd_ready, 1);
    check("idle_res_valid", res_valid, 0);
    step(1);

    // add 0111+0001: c=1000 cf0 of1 out0 zero0
    issue(4'b0111, 4'b0001, 3'b000, 1'b0, 1'b1, 8'b1000_0100);
    check("exec_busy", busy, 1);
    step(1);
    check("add_res_valid", res_valid, 1);
    check("add_acc", acc, 4'b1000);
    check("add_op_count", op_count, 1);

    // sub 0011-0011: c=0000 zero1
    issue(4'b0011, 4'b0011, 3'b001, 1'b0, 1'b1, 8'b0000_0001);
    drain();

    // chain: 0010+0011=0101, then acc+0001 with cmd_a ignored
    issue(4'b0010, 4'b0011, 3'b000, 1'b0, 1'b1, 8'b0101_0000);
    issue(4'b1111, 4'b0001, 3'b000, 1'b1, 1'b1, 8'b0110_0000);
    check("chain_alu_a", alu_a, 4'b0101);
    check("chain_alu_b", alu_b, 4'b0001);
    drain();
    check("chain_acc", acc, 4'b0110);

    // backpressure with a two-entry FIFO
    res_ready = 1'b0;
    issue(4'b0001, 4'b0001, 3'b000, 1'b0, 1'b1, 8'b0010_0000);
    issue(4'b1100, 4'b1010, 3'b101, 1'b0, 1'b1, 8'b0110_0000);
    cmd_a = 4'b1000; cmd_b = 4'b0001; cmd_sel = 3'b100; cmd_use_acc = 1'b0;
    cmd_valid = 1'b1;
    exp_q.push_back(8'b1001_0000);
    step(3);
    check("full_cmd_ready", cmd_ready, 0);
    check("full_busy", busy, 0);
    check("full_head", res_data, 8'b0010_0000);
    res_ready = 1'b1;
    step(1);
    res_ready = 1'b0;
    check("after_pop_cmd_ready", cmd_ready, 1);
    step(1);
    cmd_valid = 1'b0;
    check("third_accepted_busy", busy, 1);
    check("third_alu_sel", alu_sel, 3'b100);
    step(1);
    check("third_res_valid", res_valid, 1);
    res_ready = 1'b1;
    drain();
    check("bp_op_count", op_count, 7);

    // signed compare 1000 < 0001: c=0000 out1 zero1
    issue(4'b1000, 4'b0001, 3'b110, 1'b0, 1'b1, 8'b0000_0011);
    drain();
    check("cmp_acc", acc, 0);

    // reset during EXEC of an add discards it
    issue(4'b0001, 4'b0001, 3'b000, 1'b0, 1'b0, 8'd0);
    check("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_op_count", op_count, 0);
    check("midrst_res_valid", res_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_cmd_ready", cmd_ready, 0);
    check("midrst_acc", acc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(3);
    check("postrst_res_valid", res_valid, 0);
    check("postrst_op_count", op_count, 0);
    check("postrst_cmd_ready", cmd_ready, 1);
    check("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Sequential front/back-end wrapped around the combinational 4-bit ALU (operands a/b, 3-bit sel; result c plus cf/of/out/zero).
- Upstream side: accepts operation commands over a valid/ready handshake and drives registered operands into the ALU.
- Downstream side: captures the ALU result and flags into a small result FIFO, drained over a valid/ready handshake.
- Holds an accumulator so chained operations can reuse the previous result as operand a.

Parameters:
- WIDTH, 4, operand/result width; must match the ALU.
- DEPTH, 2, result FIFO entries; power of two, 2..8.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted this cycle when cmd_valid && cmd_ready.
- cmd_a  input  WIDTH  operand a.
- cmd_b  input  WIDTH  operand b.
- cmd_sel  input  3  ALU opcode (000 add, 001 sub, 010 not, 011 and, 100 or, 101 xor, 110 signed less-than, 111 equal).
- cmd_use_acc  input  1  1: operand a = accumulator, cmd_a ignored.
- alu_a  output  WIDTH  registered operand a to ALU.
- alu_b  output  WIDTH  registered operand b to ALU.
- alu_sel  output  3  registered opcode to ALU.
- alu_c  input  WIDTH  ALU result.
- alu_cf, alu_of, alu_out, alu_zero  input  1 each  ALU flags.
- res_valid  output  1  FIFO non-empty.
- res_ready  input  1  consumer takes head entry when res_valid && res_ready.
- res_data  output  WIDTH+4  head entry {c, cf, of, out, zero}; c in MSBs, zero in bit 0.
- acc  output  WIDTH  accumulator value.
- op_count  output  8  completed operations, wraps 255->0.
- busy  output  1  1 while in EXEC.

Behaviour:
- Reset (async assert, sync-release irrelevant to spec): state=IDLE; alu_a=alu_b=0; alu_sel=000; acc=0; op_count=0; FIFO empty; res_valid=0; res_data=0; busy=0; cmd_ready=0 only while rst_n low.
- FSM states:
  - IDLE: cmd_ready = (fifo_count < DEPTH), combinational. On handshake: alu_a <= cmd_use_acc ? acc : cmd_a; alu_b <= cmd_b; alu_sel <= cmd_sel; go EXEC.
  - EXEC: cmd_ready=0; busy=1. ALU settles during this cycle. At the end of the cycle: push {alu_c, alu_cf, alu_of, alu_out, alu_zero} into FIFO; acc <= alu_c (for every opcode, including 110/111 where c=0); op_count++; go IDLE.
- Latency: command accepted at edge N -> alu_* valid after N -> result pushed at N+1 -> res_valid=1 after N+1 (FIFO was empty). Maximum throughput is one command per 2 cycles.
- alu_* hold their last value in IDLE; no spurious pushes.
- FIFO:
  - Circular, pointers wrap mod DEPTH; res_data = head entry, combinational from storage.
  - Pop and push in the same cycle are both honoured; count is unchanged.
  - Acceptance requires count < DEPTH; count cannot rise during EXEC except by that push, so the FIFO never overflows.
  - Pop while empty is ignored.
- Full: cmd_ready=0 until a pop; a pop in IDLE raises cmd_ready in the same cycle (combinational on count after... count is registered, so cmd_ready rises the cycle after the pop).
- cmd_use_acc in back-to-back commands uses the acc updated by the previous EXEC (always written before the next IDLE acceptance).
- Reset mid-EXEC: operation is discarded; no push; all state returns to reset values.
- Flags are taken verbatim from the ALU; this block performs no arithmetic on them.

Test Plan:
- Reset -> all outputs 0; release reset with FIFO empty -> cmd_ready=1, res_valid=0.
- Add a=0111, b=0001, sel=000 -> 2 cycles after accept, res_data={1000,cf0,of1,out0,zero0}; acc=1000; op_count=1.
- Sub a=0011, b=0011, sel=001 -> c=0000, cf=0, of=0, zero=1.
- Chain: add 0010+0011, then cmd_use_acc=1, b=0001, sel=000 with cmd_a=1111 -> alu_a=0101, second result c=0110.
- Backpressure, DEPTH=2, res_ready=0: issue 3 commands -> third held (cmd_ready=0, busy=0); then res_ready=1 for one cycle -> first result popped, third accepted next cycle, results emerge in issue order.
- Signed compare a=1000, b=0001, sel=110 -> out=1, c=0000; assert rst_n low during the EXEC of a following add -> no new FIFO entry, op_count=0.
